// File: rtl/piso_tx_scheduler.sv
// Round-robin arbiter and load/shift sequencer feeding an external 8-bit PISO shift register.
// One word per frame, DIV clocks per bit, GAP idle bit-times before re-arbitration.
module piso_tx_scheduler #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIV   = 4,
    parameter int unsigned GAP   = 1
) (
    input  logic                                       clk,
    input  logic                                       reset,
    input  logic [NREQ-1:0]                            req_valid,
    input  logic [NREQ*WIDTH-1:0]                      req_data,
    output logic [NREQ-1:0]                            req_ready,
    output logic                                       sr_enable,
    output logic                                       sr_load,
    output logic [WIDTH-1:0]                           sr_parallel_in,
    output logic                                       busy,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] cur_id,
    output logic                                       done
);

    localparam int unsigned ID_W    = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DIV_W   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned GAP_CYC = GAP * DIV;
    localparam int unsigned GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

    state_t            state;
    logic [ID_W-1:0]   rr_ptr;
    logic [DIV_W-1:0]  div_cnt;
    logic [BIT_W-1:0]  bit_cnt;
    logic [GAP_W-1:0]  gap_cnt;

    logic              grant_found;
    logic [ID_W-1:0]   grant_idx;
    int unsigned       scan_idx;
    logic              div_wrap;
    logic              last_bit;
    logic [DIV_W-1:0]  div_nxt;
    logic [BIT_W-1:0]  bit_nxt;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_idx = 32'(rr_ptr) + k;
            if (scan_idx >= NREQ) begin
                scan_idx = scan_idx - NREQ;
            end
            if (!grant_found && req_valid[scan_idx]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(scan_idx);
            end
        end
    end

    // Accept is decided in the IDLE cycle itself, so ready is combinational.
    always_comb begin
        req_ready = '0;
        if (state == S_IDLE && !reset && grant_found) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    always_comb begin
        div_wrap = (div_cnt == DIV_W'(DIV - 1));
        last_bit = div_wrap && (bit_cnt == BIT_W'(WIDTH - 1));
        div_nxt  = div_wrap ? '0 : div_cnt + DIV_W'(1);
        bit_nxt  = div_wrap ? bit_cnt + BIT_W'(1) : bit_cnt;
    end

    // Strobes are computed one cycle ahead so they come straight from flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            rr_ptr         <= '0;
            cur_id         <= '0;
            sr_parallel_in <= '0;
            sr_load        <= 1'b0;
            sr_enable      <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            div_cnt        <= '0;
            bit_cnt        <= '0;
            gap_cnt        <= '0;
        end else begin
            sr_load   <= 1'b0;
            sr_enable <= 1'b0;
            done      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (grant_found) begin
                        sr_parallel_in <= req_data[grant_idx*WIDTH +: WIDTH];
                        cur_id         <= grant_idx;
                        rr_ptr         <= (grant_idx == ID_W'(NREQ - 1)) ? '0 : grant_idx + ID_W'(1);
                        state          <= S_LOAD;
                        sr_load        <= 1'b1;
                        sr_enable      <= 1'b1;
                        busy           <= 1'b1;
                    end
                end
                S_LOAD: begin
                    div_cnt   <= '0;
                    bit_cnt   <= '0;
                    state     <= S_SHIFT;
                    sr_enable <= (DIV == 1);
                    done      <= (DIV == 1) && (WIDTH == 1);
                end
                S_SHIFT: begin
                    div_cnt <= div_nxt;
                    bit_cnt <= bit_nxt;
                    if (last_bit) begin
                        if (GAP > 0) begin
                            state   <= S_GAP;
                            gap_cnt <= '0;
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        sr_enable <= (div_nxt == DIV_W'(DIV - 1));
                        done      <= (div_nxt == DIV_W'(DIV - 1)) && (bit_nxt == BIT_W'(WIDTH - 1));
                    end
                end
                S_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Directed bench for piso_tx_scheduler with a behavioural 8-bit PISO on the default instance
// and a second instance at DIV=1, GAP=0 for back-to-back spacing.
module tb_piso_tx_scheduler;

    logic        clk;
    logic        reset, reset2;
    logic [1:0]  req_valid, req_valid2;
    logic [15:0] req_data, req_data2;
    logic [1:0]  req_ready, req_ready2;
    logic        sr_enable, sr_load, busy, done;
    logic        sr_enable2, sr_load2, busy2, done2;
    logic [7:0]  sr_parallel_in, sr_parallel_in2;
    logic [0:0]  cur_id, cur_id2;
    logic [7:0]  sr;
    logic        serial_out;

    int checks = 0;
    int errors = 0;

    piso_tx_scheduler dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .sr_enable(sr_enable), .sr_load(sr_load),
        .sr_parallel_in(sr_parallel_in), .busy(busy), .cur_id(cur_id), .done(done)
    );

    piso_tx_scheduler #(.NREQ(2), .WIDTH(8), .DIV(1), .GAP(0)) dut2 (
        .clk(clk), .reset(reset2), .req_valid(req_valid2), .req_data(req_data2),
        .req_ready(req_ready2), .sr_enable(sr_enable2), .sr_load(sr_load2),
        .sr_parallel_in(sr_parallel_in2), .busy(busy2), .cur_id(cur_id2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External shift register, MSB first, sharing the scheduler reset.
    always @(posedge clk) begin
        if (reset) sr <= 8'h00;
        else if (sr_enable) sr <= sr_load ? sr_parallel_in : {sr[6:0], 1'b0};
    end
    assign serial_out = sr[7];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called in the accept cycle T; returns in cycle T+38 (next possible accept).
    task automatic frame(input logic [7:0] w, input logic [0:0] id, input logic [1:0] clr, input string tag);
        int done_at, busy_fall, bad, en_cnt, rdy_cnt;
        done_at = -1; busy_fall = -1; bad = 0; en_cnt = 0; rdy_cnt = 0;
        for (int n = 1; n <= 38; n++) begin
            step();
            if (n == 1) req_valid = req_valid & ~clr;
            #1;
            if (n == 1) begin
                chk({tag, "_load"}, 32'(sr_load), 32'd1);
                chk({tag, "_id"}, 32'(cur_id), 32'(id));
                chk({tag, "_word"}, 32'(sr_parallel_in), 32'(w));
            end
            if (n < 38 && req_ready != 2'b00) rdy_cnt++;
            if (sr_enable) en_cnt++;
            if (done && done_at < 0) done_at = n;
            if (!busy && busy_fall < 0) busy_fall = n;
            if (n >= 2 && n <= 33 && serial_out !== w[7 - (n - 2) / 4]) bad++;
            if (n >= 34 && serial_out !== 1'b0) bad++;
        end
        chk({tag, "_serial_errs"}, 32'(bad), 32'd0);
        chk({tag, "_done_at"}, 32'(done_at), 32'd33);
        chk({tag, "_busy_fall"}, 32'(busy_fall), 32'd38);
        chk({tag, "_en_pulses"}, 32'(en_cnt), 32'd9);
        chk({tag, "_ready_busy"}, 32'(rdy_cnt), 32'd0);
    endtask

    initial begin
        int bad, acc_cnt, first_acc, last_acc, en_cnt, done_cnt, spacing_bad;
        reset = 1'b1; reset2 = 1'b1;
        req_valid = 2'b00; req_valid2 = 2'b00;
        req_data = 16'h0000; req_data2 = 16'h0000;
        repeat (3) step();
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_en", 32'(sr_enable), 32'd0);
        chk("rst_load", 32'(sr_load), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_cur_id", 32'(cur_id), 32'd0);
        chk("rst_word", 32'(sr_parallel_in), 32'd0);
        chk("rst2_busy", 32'(busy2), 32'd0);

        // Long idle: nothing moves.
        bad = 0;
        for (int n = 0; n < 100; n++) begin
            step(); #1;
            if (sr_enable || sr_load || busy || req_ready != 2'b00) bad++;
        end
        chk("idle_quiet", 32'(bad), 32'd0);

        // Both valid: port 0 first (rr_ptr still 0), then port 1.
        step();
        req_valid = 2'b11; req_data = {8'hC3, 8'h3C};
        #1;
        chk("t2_ready0", 32'(req_ready), 32'h1);
        frame(8'h3C, 1'b0, 2'b01, "t2_p0");
        chk("t2_ready1", 32'(req_ready), 32'h2);
        frame(8'hC3, 1'b1, 2'b10, "t2_p1");

        // Single word 0xA5.
        req_valid = 2'b01; req_data[7:0] = 8'hA5;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        frame(8'hA5, 1'b0, 2'b01, "t1");

        // req1 held, req0 pulsed at each IDLE: grants 1,0,1,0.
        req_valid = 2'b10; req_data = {8'hC3, 8'h3C};
        #1;
        chk("t3_ready_a", 32'(req_ready), 32'h2);
        frame(8'hC3, 1'b1, 2'b00, "t3_g1a");
        req_valid[0] = 1'b1; #1;
        chk("t3_ready_b", 32'(req_ready), 32'h1);
        frame(8'h3C, 1'b0, 2'b01, "t3_g0a");
        req_valid[0] = 1'b1; #1;
        chk("t3_ready_c", 32'(req_ready), 32'h2);
        frame(8'hC3, 1'b1, 2'b01, "t3_g1b");
        req_valid[0] = 1'b1; #1;
        chk("t3_ready_d", 32'(req_ready), 32'h1);
        frame(8'h3C, 1'b0, 2'b01, "t3_g0b");

        // Reset during bit 3 of 0xF0, with req0 still pending.
        req_valid = 2'b01; req_data[7:0] = 8'hF0;
        #1;
        chk("t4_ready", 32'(req_ready), 32'h1);
        for (int n = 1; n <= 15; n++) begin
            step(); #1;
        end
        chk("t4_bit3", 32'(serial_out), 32'd1);
        reset = 1'b1; req_data[7:0] = 8'h81;
        step();
        reset = 1'b0;
        #1;
        chk("t4_busy", 32'(busy), 32'd0);
        chk("t4_en", 32'(sr_enable), 32'd0);
        chk("t4_serial", 32'(serial_out), 32'd0);
        chk("t4_ready_after", 32'(req_ready), 32'h1);
        step(); #1;
        chk("t4_busy_again", 32'(busy), 32'd1);
        chk("t4_load_again", 32'(sr_load), 32'd1);
        chk("t4_word_again", 32'(sr_parallel_in), 32'h81);
        req_valid = 2'b00; reset = 1'b1;
        repeat (2) step();
        reset = 1'b0;

        // DIV=1, GAP=0, req0 held: accept every 10 cycles.
        step();
        reset2 = 1'b0; req_valid2 = 2'b01; req_data2 = {8'h00, 8'h96};
        acc_cnt = 0; first_acc = -1; last_acc = -1; en_cnt = 0; done_cnt = 0; spacing_bad = 0;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) step();
            #1;
            if (req_ready2[0]) begin
                if (last_acc >= 0 && n - last_acc != 10) spacing_bad++;
                if (first_acc < 0) first_acc = n;
                last_acc = n;
                acc_cnt++;
            end
            if (sr_enable2) en_cnt++;
            if (done2) done_cnt++;
            if (n == 1) begin
                chk("t5_busy", 32'(busy2), 32'd1);
                chk("t5_load", 32'(sr_load2), 32'd1);
                chk("t5_word", 32'(sr_parallel_in2), 32'h96);
                chk("t5_id", 32'(cur_id2), 32'd0);
            end
        end
        chk("t5_first_acc", 32'(first_acc), 32'd0);
        chk("t5_acc_cnt", 32'(acc_cnt), 32'd4);
        chk("t5_spacing", 32'(spacing_bad), 32'd0);
        chk("t5_en_cnt", 32'(en_cnt), 32'd36);
        chk("t5_done_cnt", 32'(done_cnt), 32'd4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
